midori64_round_sequencer: RTL and testbench
===========================================

Name: midori64_round_sequencer

Overview:
- Control FSM for the masked round-based Midori64 core with a pipelined Sbox.
- Handles a start/ready handshake for a new encryption and issues the load-select pulse for the input shares.
- Sequences NUM_ROUNDS rounds of SBOX_STAGES cycles each, consuming one fresh-randomness word per pipeline cycle from the PRNG. It stalls the core when no randomness is available.
- Holds the ciphertext valid until the consumer accepts it.

Parameters:
SBOX_STAGES, 4, register stages per Sbox/round (legal 1..8)
NUM_ROUNDS, 16, rounds per encryption (legal 1..16)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request to encrypt; input shares valid on the core inputs while start=1
ready  out  1  sequencer idle; start accepted when start & ready
rnd_valid  in  1  PRNG has a fresh mask word this cycle
rnd_ack  out  1  mask word consumed this cycle
load_sel  out  1  core muxes in the input shares instead of round feedback
core_en  out  1  core state/pipeline register enable
round  out  4  current round index
stage  out  3  current Sbox pipeline stage index
last_round  out  1  round == NUM_ROUNDS-1 while running
out_valid  out  1  ciphertext shares valid on core outputs
out_ready  in  1  consumer accepts ciphertext
busy  out  1  not in IDLE

Behaviour:
- States: IDLE, LOAD, RUN, HOLD. Registered state plus round and stage counters. All outputs are a combinational decode of these.
- Reset (any cycle, including mid-encryption):
  - Next state IDLE, round=0, stage=0.
  - While reset=1, core_en, rnd_ack, load_sel and out_valid are forced to 0.
  - An aborted encryption produces no out_valid.
- After reset: ready=1, busy=0, all other outputs 0.
- IDLE:
  - ready=1, core_en=0, round=0, stage=0.
  - start=1 -> LOAD.
- LOAD (exactly 1 cycle):
  - load_sel=1, core_en=1, rnd_ack=0.
  - Core captures the input shares.
  - -> RUN with round=0, stage=0.
- RUN:
  - Step occurs iff rnd_valid=1. A step sets core_en=1 and rnd_ack=1.
  - With rnd_valid=0 (stall): core_en=0, rnd_ack=0, counters hold, state holds. Stalls may occur on any cycle, for any duration.
  - On a step with stage<SBOX_STAGES-1: stage+1.
  - On a step with stage==SBOX_STAGES-1: stage->0, round+1.
  - On a step with round==NUM_ROUNDS-1 and stage==SBOX_STAGES-1: -> HOLD.
  - Counters never exceed these bounds, so no 4-bit wrap occurs.
- HOLD:
  - out_valid=1, core_en=0, rnd_ack=0.
  - round and stage keep their final-step values, and the core state is frozen.
  - out_ready=1 -> IDLE; round and stage clear to 0.
  - start is ignored (ready=0).
- Latency, no stalls: start accepted at edge t -> out_valid high from t+2+NUM_ROUNDS*SBOX_STAGES (66 cycles at defaults). Each stall cycle adds 1.
- Throughput:
  - Back-to-back start is possible one cycle after the out_ready handshake, since IDLE is passed for at least 1 cycle.
  - Minimum period is NUM_ROUNDS*SBOX_STAGES+3 cycles.
- Simultaneous events:
  - reset beats start/out_ready.
  - out_ready while not in HOLD is ignored.
  - rnd_valid outside RUN is never acked.
- last_round=1 only in RUN when round==NUM_ROUNDS-1.
- busy=1 in LOAD, RUN and HOLD.

Test Plan:
1. Defaults, rnd_valid tied 1, start pulse at cycle 0:
   - Required: load_sel=1 at cycle 1 only, then 64 consecutive core_en/rnd_ack cycles.
   - round steps 0..15 every 4 cycles, stage cycles 0..3.
   - out_valid=1 at cycle 66 and held until out_ready.
2. Randomness stalls: rnd_valid=0 on 10 scattered RUN cycles.
   - Required: counters and core_en frozen on exactly those cycles, rnd_ack never high while rnd_valid=0.
   - Exactly 64 acks; out_valid at cycle 76.
3. Reset mid-operation: assert reset for 1 cycle at round=7, stage=2.
   - Required: next cycle IDLE, ready=1, round=0, no out_valid.
   - A following start completes a normal 64-step encryption.
4. HOLD backpressure: out_ready=0 for 20 cycles, with start=1 throughout.
   - Required: out_valid stays 1, ready=0, no core_en, start not accepted.
   - out_ready=1 -> IDLE next cycle; start is then accepted.
5. Parameter corners: SBOX_STAGES=1, NUM_ROUNDS=16.
   - Required: round increments every step; out_valid at cycle 18.
   - With SBOX_STAGES=8, NUM_ROUNDS=1: stage 0..7, last_round=1 throughout RUN, out_valid at cycle 10.
6. Boundary: rnd_valid=0 exactly on the final step cycle (round=15, stage=3).
   - Required: FSM remains in RUN with no HOLD entry until rnd_valid=1.
   - Then one ack and HOLD on the next cycle.

Source files
------------

// File: rtl/midori64_round_sequencer.sv
// rtl/midori64_round_sequencer.sv - control FSM for the masked pipelined Midori64 round core
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start / ready   new-encryption handshake (input shares valid while start=1)
//   rnd_valid       PRNG offers a fresh mask word this cycle
//   rnd_ack         mask word consumed this cycle
//   load_sel        core selects input shares instead of round feedback
//   core_en         core state / Sbox pipeline register enable
//   round, stage    current round index and Sbox pipeline stage index
//   last_round      running the final round
//   out_valid       ciphertext shares valid; held until out_ready
//   busy            sequencer not idle
module midori64_round_sequencer #(
    parameter int SBOX_STAGES = 4,
    parameter int NUM_ROUNDS  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       ready,
    input  logic       rnd_valid,
    output logic       rnd_ack,
    output logic       load_sel,
    output logic       core_en,
    output logic [3:0] round,
    output logic [2:0] stage,
    output logic       last_round,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD
    } state_t;

    localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS - 1);
    localparam logic [2:0] STAGE_LAST = 3'(SBOX_STAGES - 1);

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [2:0] stage_q, stage_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            stage_q <= 3'd0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        stage_d   = stage_q;
        ready     = 1'b0;
        load_sel  = 1'b0;
        core_en   = 1'b0;
        rnd_ack   = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready   = 1'b1;
                round_d = 4'd0;
                stage_d = 3'd0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                load_sel = 1'b1;
                core_en  = 1'b1;
                round_d  = 4'd0;
                stage_d  = 3'd0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                // Every pipeline advance needs a fresh mask word; without one the core stalls.
                if (rnd_valid) begin
                    core_en = 1'b1;
                    rnd_ack = 1'b1;
                    if (stage_q == STAGE_LAST) begin
                        if (round_q == ROUND_LAST) begin
                            // Final step: counters keep their last values for observation in HOLD.
                            state_d = S_HOLD;
                        end else begin
                            stage_d = 3'd0;
                            round_d = round_q + 4'd1;
                        end
                    end else begin
                        stage_d = stage_q + 3'd1;
                    end
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                    round_d = 4'd0;
                    stage_d = 3'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Keep the core and PRNG untouched while reset is asserted, even mid-encryption.
        if (reset) begin
            load_sel  = 1'b0;
            core_en   = 1'b0;
            rnd_ack   = 1'b0;
            out_valid = 1'b0;
        end
    end

    assign round      = round_q;
    assign stage      = stage_q;
    assign busy       = (state_q != S_IDLE);
    assign last_round = (state_q == S_RUN) && (round_q == ROUND_LAST);

endmodule

// File: tb/tb_midori64_round_sequencer.sv
// tb/tb_midori64_round_sequencer.sv - self-checking bench for midori64_round_sequencer
module tb_midori64_round_sequencer;

    logic clk = 1'b0;
    logic reset, start, rnd_valid, out_ready;

    logic       ready, rnd_ack, load_sel, core_en, last_round, out_valid, busy;
    logic [3:0] round;
    logic [2:0] stage;

    logic       a_ready, a_rnd_ack, a_load_sel, a_core_en, a_last_round, a_out_valid, a_busy;
    logic [3:0] a_round;
    logic [2:0] a_stage;

    logic       b_ready, b_rnd_ack, b_load_sel, b_core_en, b_last_round, b_out_valid, b_busy;
    logic [3:0] b_round;
    logic [2:0] b_stage;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    midori64_round_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .rnd_valid(rnd_valid), .rnd_ack(rnd_ack), .load_sel(load_sel),
        .core_en(core_en), .round(round), .stage(stage), .last_round(last_round),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    midori64_round_sequencer #(.SBOX_STAGES(1), .NUM_ROUNDS(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .ready(a_ready),
        .rnd_valid(rnd_valid), .rnd_ack(a_rnd_ack), .load_sel(a_load_sel),
        .core_en(a_core_en), .round(a_round), .stage(a_stage), .last_round(a_last_round),
        .out_valid(a_out_valid), .out_ready(out_ready), .busy(a_busy)
    );

    midori64_round_sequencer #(.SBOX_STAGES(8), .NUM_ROUNDS(1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .ready(b_ready),
        .rnd_valid(rnd_valid), .rnd_ack(b_rnd_ack), .load_sel(b_load_sel),
        .core_en(b_core_en), .round(b_round), .stage(b_stage), .last_round(b_last_round),
        .out_valid(b_out_valid), .out_ready(out_ready), .busy(b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one encryption from the current (IDLE) cycle; returns at the first HOLD cycle.
    task automatic encrypt(input string name, input bit [127:0] stall, input int exp_hold);
        int  acks;
        bit  done;
        acks = 0;
        done = 0;
        exp_q.delete();
        for (int r = 0; r < 16; r++)
            for (int s = 0; s < 4; s++)
                exp_q.push_back({4'(r), 3'(s)});
        start = 1'b1;
        rnd_valid = !stall[0];
        #1;
        checks++;
        if (ready !== 1'b1 || load_sel !== 1'b0 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL %s start_cycle ready=%b load_sel=%b core_en=%b required 1 0 0", name, ready, load_sel, core_en);
        end
        step();
        start = 1'b0;
        rnd_valid = !stall[1];
        #1;
        checks++;
        if (load_sel !== 1'b1 || core_en !== 1'b1 || rnd_ack !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL %s load_cycle load_sel=%b core_en=%b rnd_ack=%b busy=%b ready=%b required 1 1 0 1 0",
                     name, load_sel, core_en, rnd_ack, busy, ready);
        end
        for (int c = 2; c < 300 && !done; c++) begin
            step();
            rnd_valid = (c < 128) ? !stall[c] : 1'b1;
            #1;
            if (exp_q.size() > 0) begin
                checks++;
                if ({round, stage} !== exp_q[0] || core_en !== rnd_valid || rnd_ack !== rnd_valid ||
                    last_round !== (exp_q[0][6:3] == 4'd15) || out_valid !== 1'b0 || load_sel !== 1'b0) begin
                    errors++;
                    $display("FAIL %s run_c%0d round=%0d stage=%0d core_en=%b rnd_ack=%b last=%b out_valid=%b load_sel=%b required round=%0d stage=%0d en/ack=%b last=%b 0 0",
                             name, c, round, stage, core_en, rnd_ack, last_round, out_valid, load_sel,
                             exp_q[0][6:3], exp_q[0][2:0], rnd_valid, (exp_q[0][6:3] == 4'd15));
                end
                if (rnd_ack === 1'b1) acks++;
                if (rnd_valid) void'(exp_q.pop_front());
            end else begin
                done = 1;
                checks++;
                if (out_valid !== 1'b1 || c != exp_hold || round !== 4'd15 || stage !== 3'd3 || rnd_ack !== 1'b0 || core_en !== 1'b0) begin
                    errors++;
                    $display("FAIL %s hold_entry cycle=%0d out_valid=%b round=%0d stage=%0d ack=%b en=%b required cycle=%0d 1 15 3 0 0",
                             name, c, out_valid, round, stage, rnd_ack, core_en, exp_hold);
                end
                checks++;
                if (acks != 64) begin
                    errors++;
                    $display("FAIL %s ack_count got=%0d required=64", name, acks);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout no HOLD within 300 cycles", name);
        end
    endtask

    // Keeps HOLD for n more cycles with out_ready=0, then hands off; ends on the IDLE cycle.
    task automatic hold_phase(input string name, input int n, input logic st);
        for (int i = 0; i < n; i++) begin
            step();
            out_ready = 1'b0;
            start = st;
            rnd_valid = 1'b1;
            #1;
            checks++;
            if (out_valid !== 1'b1 || ready !== 1'b0 || core_en !== 1'b0 || rnd_ack !== 1'b0 ||
                load_sel !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s hold_%0d out_valid=%b ready=%b core_en=%b rnd_ack=%b load_sel=%b busy=%b required 1 0 0 0 0 1",
                         name, i, out_valid, ready, core_en, rnd_ack, load_sel, busy);
            end
        end
        step();
        start = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s handoff_cycle out_valid=%b required 1", name, out_valid);
        end
        step();
        out_ready = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || round !== 4'd0 || stage !== 3'd0 || out_valid !== 1'b0 || rnd_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after ready=%b busy=%b round=%0d stage=%0d out_valid=%b rnd_ack=%b required 1 0 0 0 0 0",
                     name, ready, busy, round, stage, out_valid, rnd_ack);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        rnd_valid = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        #1;
        checks++;
        if (core_en !== 1'b0 || rnd_ack !== 1'b0 || load_sel !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_forced core_en=%b rnd_ack=%b load_sel=%b out_valid=%b required 0 0 0 0",
                     core_en, rnd_ack, load_sel, out_valid);
        end
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        step();
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || rnd_ack !== 1'b0 || load_sel !== 1'b0 || core_en !== 1'b0 ||
            round !== 4'd0 || stage !== 3'd0 || last_round !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state ready=%b busy=%b ack=%b load=%b en=%b round=%0d stage=%0d last=%b ov=%b required 1 0 0 0 0 0 0 0 0",
                     ready, busy, rnd_ack, load_sel, core_en, round, stage, last_round, out_valid);
        end
    endtask

    task automatic test_nominal();
        encrypt("nominal", 128'd0, 66);
        hold_phase("nominal", 3, 1'b0);
    endtask

    task automatic test_stalls();
        bit [127:0] m;
        m = 128'd0;
        m[3] = 1; m[7] = 1; m[8] = 1; m[20] = 1; m[33] = 1;
        m[40] = 1; m[41] = 1; m[50] = 1; m[60] = 1; m[64] = 1;
        encrypt("stalls", m, 76);
        hold_phase("stalls", 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit seen_ov;
        start = 1'b1;
        rnd_valid = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 32; c++) step();
        #1;
        checks++;
        if (round !== 4'd7 || stage !== 3'd2) begin
            errors++;
            $display("FAIL reset_mid_position round=%0d stage=%0d required 7 2", round, stage);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (core_en !== 1'b0 || rnd_ack !== 1'b0 || load_sel !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_forced core_en=%b rnd_ack=%b load_sel=%b out_valid=%b required 0 0 0 0",
                     core_en, rnd_ack, load_sel, out_valid);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || round !== 4'd0 || stage !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle ready=%b busy=%b round=%0d stage=%0d out_valid=%b required 1 0 0 0 0",
                     ready, busy, round, stage, out_valid);
        end
        seen_ov = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (out_valid !== 1'b0 || rnd_ack !== 1'b0) seen_ov = 1;
        end
        checks++;
        if (seen_ov) begin
            errors++;
            $display("FAIL reset_mid_abort out_valid/rnd_ack seen=1 required 0");
        end
        encrypt("after_reset", 128'd0, 66);
        hold_phase("after_reset", 0, 1'b0);
    endtask

    task automatic test_hold_backpressure();
        encrypt("backpressure", 128'd0, 66);
        hold_phase("backpressure", 20, 1'b1);
    endtask

    task automatic test_back_to_back();
        // Starts on the single IDLE cycle right after the previous handoff.
        encrypt("back_to_back", 128'd0, 66);
        hold_phase("back_to_back", 0, 1'b0);
    endtask

    task automatic test_final_stall();
        bit [127:0] m;
        m = 128'd0;
        m[65] = 1; m[66] = 1; m[67] = 1;
        encrypt("final_stall", m, 69);
        hold_phase("final_stall", 0, 1'b0);
    endtask

    task automatic test_corners();
        start = 1'b1;
        rnd_valid = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 70; c++) begin
            if (c > 1) step();
            #1;
            checks++;
            if (a_out_valid !== (c >= 18) ||
                (c >= 2 && c < 18 && (a_round !== 4'(c - 2) || a_stage !== 3'd0 || a_rnd_ack !== 1'b1 ||
                                       a_last_round !== (c == 17)))) begin
                errors++;
                $display("FAIL corner_s1_c%0d out_valid=%b round=%0d stage=%0d ack=%b last=%b required ov=%b round=%0d",
                         c, a_out_valid, a_round, a_stage, a_rnd_ack, a_last_round, (c >= 18), c - 2);
            end
            checks++;
            if (b_out_valid !== (c >= 10) ||
                (c >= 2 && c < 10 && (b_stage !== 3'(c - 2) || b_round !== 4'd0 || b_last_round !== 1'b1 ||
                                       b_rnd_ack !== 1'b1))) begin
                errors++;
                $display("FAIL corner_s8_c%0d out_valid=%b round=%0d stage=%0d ack=%b last=%b required ov=%b stage=%0d last=1",
                         c, b_out_valid, b_round, b_stage, b_rnd_ack, b_last_round, (c >= 10), c - 2);
            end
            checks++;
            if (out_valid !== (c >= 66)) begin
                errors++;
                $display("FAIL corner_default_c%0d out_valid=%b required %b", c, out_valid, (c >= 66));
            end
        end
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || a_ready !== 1'b1 || b_ready !== 1'b1 || a_round !== 4'd0 || b_stage !== 3'd0) begin
            errors++;
            $display("FAIL corner_release ready=%b/%b/%b a_round=%0d b_stage=%0d required 1/1/1 0 0",
                     ready, a_ready, b_ready, a_round, b_stage);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rnd_valid = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_nominal();
        test_stalls();
        test_reset_mid();
        test_hold_backpressure();
        test_back_to_back();
        test_final_stall();
        test_corners();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
